axi_ram_slave: RTL and testbench
================================

# axi_ram_slave

AXI4 memory-mapped responder backed by on-chip dual-port RAM. It terminates one master port of `axiCrossbar` and serves the crossbar's write and read traffic. It handles FIXED, INCR and WRAP bursts with byte strobes. Write and read paths run independently, each with one outstanding transaction.

## Interface
- `C_AXI_ID_WIDTH`, default 1: width of the ID fields, echoed unchanged.
- `C_AXI_ADDR_WIDTH`, default 32: AXI byte-address width.
- `C_AXI_DATA_WIDTH`, default 32: data width; legal values 32, 64, 128.
- `C_MEM_ADDR_WIDTH`, default 10: RAM depth is 2^C_MEM_ADDR_WIDTH words.
- `aclk`  in  1  sole clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axi_awid/awaddr/awlen/awsize/awburst`  in  ID/ADDR/8/3/2  write-address payload.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1  AW handshake.
- `s_axi_wdata/wstrb/wlast`  in  DATA/DATA/8/1  write-data payload.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1  W handshake.
- `s_axi_bid/bresp`  out  ID/2  write response.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1  B handshake.
- `s_axi_arid/araddr/arlen/arsize/arburst`  in  ID/ADDR/8/3/2  read-address payload.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1  AR handshake.
- `s_axi_rid/rdata/rresp/rlast`  out  ID/DATA/2/1  read-data payload.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1  R handshake.

## Operation
- **Write FSM:** W_IDLE → W_DATA → W_RESP → W_IDLE.
  - `awready` = (state == W_IDLE). An AW handshake latches id, addr, len, size and burst, and clears the beat count.
  - `wready` = (state == W_DATA). Each W handshake writes the RAM word at the current address, byte lane i only where `wstrb[i]` = 1. The address then advances.
  - The FSM leaves W_DATA on the handshake whose beat count equals awlen. `wlast` is ignored for termination.
  - A `wlast` that does not match the beat count, or any beat whose address is out of range, sets a sticky error flag.
  - W_RESP: `bvalid` = 1, `bid` = latched id, `bresp` = SLVERR (2'b10) if the error flag is set, else OKAY (2'b00). A B handshake returns the FSM to W_IDLE.
- **Read FSM:** R_IDLE → R_LOAD → R_DATA.
  - `arready` = (state == R_IDLE). An AR handshake latches the payload.
  - R_LOAD issues a synchronous RAM read.
  - R_DATA drives `rvalid` = 1, `rid`, `rdata`, `rlast` = (beat == arlen).
  - On an R handshake: if last, go to R_IDLE; otherwise advance the address and go to R_LOAD.
  - Out-of-range beats return `rdata` = 0 and `rresp` = SLVERR; other beats return OKAY.
- **Address generation** (identical for both paths):
  - Step = 1 << size. `size` above log2(DATA/8) is treated as an error and clamped to full width.
  - FIXED: the address is held.
  - INCR: the address is aligned to the step, then the step is added. An unaligned first beat uses its own address; later beats are aligned.
  - WRAP: wrap length = (len+1) << size, with len in {1,3,7,15}. The new address is the wrap-aligned base OR ((addr + step) mod wrap length). Any other len sets the error flag and the burst behaves as INCR.
  - Word index = addr[C_MEM_ADDR_WIDTH+lsb-1 : lsb], where lsb = log2(DATA/8). The address is out of range if any bit above that field is nonzero.
- **RAM:** true dual-port, read-first. A simultaneous read and write to the same word returns the old data. RAM contents are not reset.

## Timing
- **Reset values:**
  - `awready` = 1, `arready` = 1.
  - `wready`, `bvalid`, `rvalid`, `rlast` = 0.
  - `bresp`, `rresp`, `bid`, `rid`, `rdata` = 0.
- **Write timing:**
  - AW handshake at cycle N → `wready` high at N+1.
  - W beats are accepted at one per cycle while `wvalid` is high.
  - Last W handshake at cycle M → `bvalid` high at M+1, held until `bready`.
- **Read timing:**
  - AR handshake at N → `rvalid` at N+2.
  - Each R handshake at M → next `rvalid` at M+2. Sustained rate is 1 beat per 2 cycles.
- **Handshake rule:** `bvalid`/`rvalid` and their payloads stay stable until the handshake completes; they never drop while waiting for ready.
- **Ready dependencies:** `awready`/`arready` do not depend on `awvalid`/`arvalid`. A new AW is accepted only after the B handshake, and a new AR only after the last R handshake.
- **Concurrency:** read and write channels may be active in the same cycle with no interaction other than RAM read-first.
- **Reset mid-burst:** both FSMs return to idle asynchronously. `bvalid`/`rvalid` drop immediately. Partially written RAM data is retained.
- **Beat count:** the counter is 8 bits and the maximum awlen of 255 gives 256 beats, so the counter never wraps within a burst.

## Structure
- Package `axi_pkg`:
  - burst encodings (FIXED = 0, INCR = 1, WRAP = 2);
  - response codes (OKAY = 0, SLVERR = 2);
  - write and read state enums;
  - function `axi_next_addr(addr, size, len, burst)`.
- Sub-module `axi_burst_addr`: holds the current address and beat count, and flags last beat, out-of-range and WRAP-length error. It is instantiated once per direction.
- Top level: the two FSMs plus the dual-port RAM array.

## Test plan
- **INCR write and read back:** AW addr 0x10, len 3, size 2, data 0xA0..0xA3, full strobes → `bresp` OKAY. AR with the same parameters returns 0xA0..0xA3 with `rlast` only on beat 3, and `rid` = `arid`.
- **Partial strobe:** write 0xFFFFFFFF to 0x0, then write 0x12345678 to 0x0 with strobe 4'b0101 → read returns 0xFF34FF78.
- **WRAP:** AW addr 0x18, len 3, size 2 writes words at 0x18, 0x1C, 0x10, 0x14. An INCR read of 0x10..0x1C returns beats 2, 3, 0, 1 in that order.
- **FIXED:** len 3 write to 0x40 with data 1..4 → a read of 0x40 returns 4.
- **Errors:**
  - a write at 2^C_MEM_ADDR_WIDTH·4 returns `bresp` SLVERR and leaves RAM unchanged;
  - a read at the same address returns `rdata` 0 with SLVERR;
  - a `wlast` asserted early returns SLVERR.
- **Back-pressure and reset:**
  - hold `bready`/`rready` low for 5 cycles → `bvalid`/`rvalid` and their payloads stay stable;
  - assert `aresetn` low mid-read-burst → `rvalid` drops at once and `arready` = 1 after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and burst address arithmetic for axi_ram_slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic [1:0] {RIdle, RLoad, RData} rstate_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of the beat following addr; size must already be clamped to the bus width.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr, input logic [2:0] size,
                                                input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && wrap_len_ok(len)) return (addr & ~mask) | ((addr + step) & mask);
    return (addr & ~(step - 64'd1)) + step;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Per-direction burst tracker: current address, beat count and per-beat status flags.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MemAddrWidth = 10,
  parameter bit          CfgCheck     = 1'b1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    advance,
  input  logic [AddrWidth-1:0]    addr_in,
  input  logic [7:0]              len_in,
  input  logic [2:0]              size_in,
  input  logic [1:0]              burst_in,
  output logic                    last,
  output logic                    oor,
  output logic                    beat_err,
  output logic [MemAddrWidth-1:0] word_idx
);

  localparam int unsigned Lsb   = $clog2(DataWidth / 8);
  localparam int unsigned HiBit = MemAddrWidth + Lsb;

  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           beat_q, len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic                 size_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q     <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_INCR;
      size_err_q <= 1'b0;
    end else if (start) begin
      addr_q     <= addr_in;
      beat_q     <= '0;
      len_q      <= len_in;
      burst_q    <= burst_in;
      // Oversized transfers are clamped to the bus width and reported as an error.
      size_err_q <= (size_in > 3'(Lsb));
      size_q     <= (size_in > 3'(Lsb)) ? 3'(Lsb) : size_in;
    end else if (advance) begin
      addr_q <= AddrWidth'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));
      beat_q <= beat_q + 8'd1;
    end
  end

  assign last     = (beat_q == len_q);
  assign oor      = ((addr_q >> HiBit) != '0);
  assign word_idx = addr_q[HiBit-1:Lsb];
  assign beat_err = oor | (CfgCheck & (size_err_q |
                    ((burst_q == BURST_WRAP) && !wrap_len_ok(len_q))));

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by a read-first dual-port RAM; independent single-outstanding W and R paths.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int unsigned C_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_ADDR_WIDTH = 10
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int unsigned Strb  = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned Depth = 2 ** C_MEM_ADDR_WIDTH;

  logic [C_AXI_DATA_WIDTH-1:0] mem [Depth];

  wstate_e w_state_q;
  rstate_e r_state_q;
  logic    err_q, rdata_en_q;
  logic [C_AXI_DATA_WIDTH-1:0] ram_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_last, wr_oor, wr_err, wr_beat_err;
  logic rd_last, rd_oor, rd_err;
  logic [C_MEM_ADDR_WIDTH-1:0] wr_idx, rd_idx;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  axi_burst_addr #(
    .AddrWidth(C_AXI_ADDR_WIDTH), .DataWidth(C_AXI_DATA_WIDTH),
    .MemAddrWidth(C_MEM_ADDR_WIDTH), .CfgCheck(1'b1)
  ) u_wr_addr (
    .aclk(aclk), .aresetn(aresetn), .start(aw_hs), .advance(w_hs),
    .addr_in(s_axi_awaddr), .len_in(s_axi_awlen), .size_in(s_axi_awsize),
    .burst_in(s_axi_awburst), .last(wr_last), .oor(wr_oor), .beat_err(wr_beat_err),
    .word_idx(wr_idx)
  );

  axi_burst_addr #(
    .AddrWidth(C_AXI_ADDR_WIDTH), .DataWidth(C_AXI_DATA_WIDTH),
    .MemAddrWidth(C_MEM_ADDR_WIDTH), .CfgCheck(1'b0)
  ) u_rd_addr (
    .aclk(aclk), .aresetn(aresetn), .start(ar_hs), .advance(r_hs & ~s_axi_rlast),
    .addr_in(s_axi_araddr), .len_in(s_axi_arlen), .size_in(s_axi_arsize),
    .burst_in(s_axi_arburst), .last(rd_last), .oor(rd_oor), .beat_err(rd_err),
    .word_idx(rd_idx)
  );

  // Termination follows the beat count; a disagreeing wlast only poisons the response.
  assign wr_err = err_q | wr_beat_err | (s_axi_wlast != wr_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q     <= WIdle;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      err_q         <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: if (aw_hs) begin
          s_axi_bid     <= s_axi_awid;
          err_q         <= 1'b0;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          w_state_q     <= WData;
        end
        WData: if (w_hs) begin
          err_q <= wr_err;
          if (wr_last) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state_q    <= WResp;
          end
        end
        WResp: if (b_hs) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          w_state_q     <= WIdle;
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && !wr_oor) begin
      for (int i = 0; i < Strb; i++) begin
        if (s_axi_wstrb[i]) mem[wr_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // Unreset read register keeps the array mappable to block RAM; rdata_en_q masks it.
  always_ff @(posedge aclk) begin
    if (r_state_q == RLoad) ram_q <= mem[rd_idx];
  end

  assign s_axi_rdata = rdata_en_q ? ram_q : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q     <= RIdle;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      rdata_en_q    <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: if (ar_hs) begin
          s_axi_rid     <= s_axi_arid;
          s_axi_arready <= 1'b0;
          r_state_q     <= RLoad;
        end
        RLoad: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rlast  <= rd_last;
          s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
          rdata_en_q   <= ~rd_oor;
          r_state_q    <= RData;
        end
        RData: if (r_hs) begin
          s_axi_rvalid <= 1'b0;
          if (s_axi_rlast) begin
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state_q     <= RIdle;
          end else begin
            r_state_q <= RLoad;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed and randomized bursts against a word-array model of the 4 KiB RAM.
module tb_axi_ram_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [0:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_ram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 aclk = ~aclk;

  int vecs = 0;
  int errs = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic [31:0] rdat [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form byte address of beat i of a burst.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
    longint s, step, wl, base;
    s    = longint'(start);
    step = longint'(1) << ((size > 3'd2) ? 2 : int'(size));
    if (burst == 2'd0) return start;
    if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wl   = (longint'(len) + 1) * step;
      base = (s / wl) * wl;
      return 32'(base + ((s - base) + longint'(i) * step) % wl);
    end
    if (i == 0) return start;
    return 32'((s / step) * step + longint'(i) * step);
  endfunction

  task automatic wait_cycles_until(input string what, output int c);
    c = 0;
    while (c < 50) begin
      if (what == "aw" && s_axi_awready) break;
      if (what == "w" && s_axi_wready) break;
      if (what == "ar" && s_axi_arready) break;
      if (what == "r" && s_axi_rvalid) break;
      @(posedge aclk); #1;
      c++;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int early, input int bstall);
    logic [0:0]  id;
    logic        exp_err, wl_bit;
    logic [31:0] a;
    int          c;
    id = 1'($urandom);
    exp_err = (size > 3'd2) || (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    wait_cycles_until("aw", c);
    check("awready", 64'(s_axi_awready), 64'd1);
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    check("wready_after_aw", 64'(s_axi_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wl_bit = (early >= 0) ? (i == early) : (i == int'(len));
      if (wl_bit != (i == int'(len))) exp_err = 1'b1;
      a = beat_addr(addr, size, len, burst, i);
      if (a >= 32'd4096) exp_err = 1'b1;
      else for (int b = 0; b < 4; b++) if (wstb[i][b]) model_mem[a[11:2]][b*8 +: 8] = wdat[i][b*8 +: 8];
      s_axi_wdata = wdat[i]; s_axi_wstrb = wstb[i]; s_axi_wlast = wl_bit; s_axi_wvalid = 1'b1;
      wait_cycles_until("w", c);
      if (c != 0) check("wready_beat", 64'(c), 64'd0);
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid", 64'(s_axi_bvalid), 64'd1);
    check("bid", 64'(s_axi_bid), 64'(id));
    check("bresp", 64'(s_axi_bresp), exp_err ? 64'd2 : 64'd0);
    for (int k = 0; k < bstall; k++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
      check("bresp_hold", 64'(s_axi_bresp), exp_err ? 64'd2 : 64'd0);
      check("bid_hold", 64'(s_axi_bid), 64'(id));
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_drop", 64'(s_axi_bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall);
    logic [0:0]  id;
    logic [31:0] a, expd;
    logic [1:0]  exprsp;
    int          c, st;
    id = 1'($urandom);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    wait_cycles_until("ar", c);
    check("arready", 64'(s_axi_arready), 64'd1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      expd   = (a >= 32'd4096) ? 32'd0 : model_mem[a[11:2]];
      exprsp = (a >= 32'd4096) ? 2'd2 : 2'd0;
      check("rvalid_gap", 64'(s_axi_rvalid), 64'd0);
      wait_cycles_until("r", c);
      check("rvalid_latency", 64'(c), 64'd1);
      check("rdata", 64'(s_axi_rdata), 64'(expd));
      check("rresp", 64'(s_axi_rresp), 64'(exprsp));
      check("rlast", 64'(s_axi_rlast), 64'(i == int'(len)));
      check("rid", 64'(s_axi_rid), 64'(id));
      rdat[i] = s_axi_rdata;
      st = (stall >= 0) ? stall : int'($urandom_range(0, 2));
      for (int k = 0; k < st; k++) begin
        @(posedge aclk); #1;
        check("rvalid_hold", 64'(s_axi_rvalid), 64'd1);
        check("rdata_hold", 64'(s_axi_rdata), 64'(expd));
        check("rresp_hold", 64'(s_axi_rresp), 64'(exprsp));
      end
      s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      s_axi_rready = 1'b0;
    end
    check("arready_after_last", 64'(s_axi_arready), 64'd1);
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          early, c;
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready} = '0;
    {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid} = '0;
    s_axi_rready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("rst_awready", 64'(s_axi_awready), 64'd1);
    check("rst_arready", 64'(s_axi_arready), 64'd1);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("rst_resps", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    check("rst_ids", 64'({s_axi_bid, s_axi_rid}), 64'd0);
    check("rst_rdata", 64'(s_axi_rdata), 64'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Fill the whole RAM so every later read has a defined expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(32'(blk * 1024), 8'd255, 3'd2, 2'd1, -1, 0);
    end

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h10, 8'd3, 3'd2, 2'd1, -1, 0);
    do_read(32'h10, 8'd3, 3'd2, 2'd1, 0);
    for (int i = 0; i < 4; i++) check("incr_readback", 64'(rdat[i]), 64'h0A0 + 64'(i));

    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    do_write(32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
    wdat[0] = 32'h1234_5678; wstb[0] = 4'b0101;
    do_write(32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
    do_read(32'h0, 8'd0, 3'd2, 2'd1, 0);
    check("partial_strobe", 64'(rdat[0]), 64'hFF34_FF78);

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hB0 + 32'(i); wstb[i] = 4'hF; end
    do_write(32'h18, 8'd3, 3'd2, 2'd2, -1, 0);
    do_read(32'h10, 8'd3, 3'd2, 2'd1, 0);
    check("wrap_b0", 64'(rdat[0]), 64'hB2);
    check("wrap_b1", 64'(rdat[1]), 64'hB3);
    check("wrap_b2", 64'(rdat[2]), 64'hB0);
    check("wrap_b3", 64'(rdat[3]), 64'hB1);

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(32'h40, 8'd3, 3'd2, 2'd0, -1, 0);
    do_read(32'h40, 8'd0, 3'd2, 2'd1, 0);
    check("fixed_last_wins", 64'(rdat[0]), 64'd4);

    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    do_write(32'd4096, 8'd0, 3'd2, 2'd1, -1, 0);
    do_read(32'h0, 8'd0, 3'd2, 2'd1, 0);
    do_read(32'd4096, 8'd0, 3'd2, 2'd1, 0);
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(32'h80, 8'd3, 3'd2, 2'd1, 1, 0);

    do_write(32'h200, 8'd3, 3'd2, 2'd1, -1, 5);
    do_read(32'h200, 8'd3, 3'd2, 2'd1, 5);

    for (int t = 0; t < 30; t++) begin
      burst = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0: len = 8'd1;
        1: len = 8'd3;
        2: len = 8'd7;
        3: len = 8'd15;
        default: len = 8'($urandom_range(0, 20));
      endcase
      size = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      addr = ($urandom_range(0, 5) == 0) ? 32'(4096 - $urandom_range(0, 32))
                                         : 32'($urandom_range(0, 4095));
      if (burst == 2'd2) addr = addr & ~((32'd1 << ((size > 3'd2) ? 2 : int'(size))) - 32'd1);
      early = (len > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
      for (int i = 0; i <= int'(len); i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      do_write(addr, len, size, burst, early, int'($urandom_range(0, 2)));
      do_read(addr, len, size, burst, -1);
    end

    // Reset in the middle of a read burst.
    s_axi_arid = 1'b1; s_axi_araddr = 32'h100; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
    wait_cycles_until("ar", c);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    wait_cycles_until("r", c);
    check("mid_rvalid0", 64'(s_axi_rvalid), 64'd1);
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    wait_cycles_until("r", c);
    check("mid_rvalid1", 64'(s_axi_rvalid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("mid_rst_rlast", 64'(s_axi_rlast), 64'd0);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_arready", 64'(s_axi_arready), 64'd1);
    check("post_rst_awready", 64'(s_axi_awready), 64'd1);
    do_read(32'h100, 8'd7, 3'd2, 2'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
